// File: rtl/acc_drain_seq.sv
`default_nettype none
// acc_drain_seq: walks NUM_COLS accumulator banks in lock-step and streams one row per beat.
// Build option CLEAR_ON_READ_EN: zero each bank row in the cycle right after it is captured.
module acc_drain_seq #(
   parameter int DEPTH_LOG2 = 8,
   parameter int NUM_COLS   = 16,
   parameter int ACC_WIDTH  = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [DEPTH_LOG2:0]           num_rows,
   output logic                          busy,
   output logic                          done,
   output logic [DEPTH_LOG2-1:0]         bank_addr,
   output logic                          bank_wr_en,
   output logic                          bank_acc_mode,
   output logic [NUM_COLS*ACC_WIDTH-1:0] bank_psum,
   input  logic [NUM_COLS*ACC_WIDTH-1:0] bank_rd_data,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [NUM_COLS*ACC_WIDTH-1:0] m_data,
   output logic [DEPTH_LOG2-1:0]         m_row,
   output logic                          m_last
);

   localparam int                  W          = NUM_COLS * ACC_WIDTH;
   localparam logic [DEPTH_LOG2:0] C_MAX_ROWS = {1'b1, {DEPTH_LOG2{1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
`ifdef CLEAR_ON_READ_EN
      S_CLEAR = 2'd2,
`endif
      S_FLUSH = 2'd3
   } state_t;

   state_t                state_q;
   logic [DEPTH_LOG2:0]   row_q;
   logic [DEPTH_LOG2:0]   n_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  valid_q;
   logic [W-1:0]          data_q;
   logic [DEPTH_LOG2-1:0] mrow_q;
   logic                  last_q;
   logic [DEPTH_LOG2-1:0] addr_q;

   logic [DEPTH_LOG2:0]   n_d;
   logic                  capture;
   logic                  last_hs;
   logic                  row_is_last;

   // Requests beyond the bank depth are clamped so the walk never wraps.
   assign n_d         = (num_rows > C_MAX_ROWS) ? C_MAX_ROWS : num_rows;
   assign capture     = !valid_q || m_ready;
   assign last_hs     = valid_q && m_ready && last_q;
   assign row_is_last = (row_q == n_q - 1'b1);

`ifdef CLEAR_ON_READ_EN
   logic wr_en_q;
   assign bank_wr_en = wr_en_q;
`else
   assign bank_wr_en = 1'b0;
`endif
   assign bank_acc_mode = 1'b0;
   assign bank_psum     = '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         n_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
         mrow_q  <= '0;
         last_q  <= 1'b0;
         addr_q  <= '0;
`ifdef CLEAR_ON_READ_EN
         wr_en_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         if (valid_q && m_ready) begin
            valid_q <= 1'b0;
         end
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (num_rows == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     n_q     <= n_d;
                     row_q   <= '0;
                     addr_q  <= '0;
                     busy_q  <= 1'b1;
                     state_q <= S_READ;
                  end
               end
            end
            S_READ: begin
               if (capture) begin
                  valid_q <= 1'b1;
                  data_q  <= bank_rd_data;
                  mrow_q  <= row_q[DEPTH_LOG2-1:0];
                  last_q  <= row_is_last;
`ifdef CLEAR_ON_READ_EN
                  wr_en_q <= 1'b1;
                  state_q <= S_CLEAR;
`else
                  if (row_is_last) begin
                     state_q <= S_FLUSH;
                  end else begin
                     row_q  <= row_q + 1'b1;
                     addr_q <= row_q[DEPTH_LOG2-1:0] + 1'b1;
                  end
`endif
               end
            end
`ifdef CLEAR_ON_READ_EN
            S_CLEAR: begin
               wr_en_q <= 1'b0;
               if (row_is_last) begin
                  // The last beat can already handshake while its row is being cleared.
                  if (last_hs) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end else begin
                     state_q <= S_FLUSH;
                  end
               end else begin
                  row_q   <= row_q + 1'b1;
                  addr_q  <= row_q[DEPTH_LOG2-1:0] + 1'b1;
                  state_q <= S_READ;
               end
            end
`endif
            S_FLUSH: begin
               if (last_hs) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign bank_addr = addr_q;
   assign m_valid   = valid_q;
   assign m_data    = data_q;
   assign m_row     = mrow_q;
   assign m_last    = last_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_drain_seq.sv
`default_nettype none
// tb_acc_drain_seq: bank model plus row-queue scoreboard for acc_drain_seq.
// Build option CLEAR_ON_READ_EN adds the clear-after-read scenario.
module tb_acc_drain_seq;

   localparam int D    = 8;
   localparam int NC   = 16;
   localparam int AW   = 32;
   localparam int W    = NC * AW;
   localparam int ROWS = 1 << D;
`ifdef CLEAR_ON_READ_EN
   localparam int SP = 2;
`else
   localparam int SP = 1;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [D:0]   num_rows = '0;
   logic         m_ready = 1'b1;
   logic         busy, done, bank_wr_en, bank_acc_mode, m_valid, m_last;
   logic [D-1:0] bank_addr, m_row;
   logic [W-1:0] bank_psum, bank_rd_data, m_data;

   acc_drain_seq #(.DEPTH_LOG2(D), .NUM_COLS(NC), .ACC_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
      .busy(busy), .done(done), .bank_addr(bank_addr), .bank_wr_en(bank_wr_en),
      .bank_acc_mode(bank_acc_mode), .bank_psum(bank_psum), .bank_rd_data(bank_rd_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_row(m_row), .m_last(m_last)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // Bank model: asynchronous read, write data bypassed onto the read port while written.
   logic [AW-1:0] mem [ROWS][NC];
   always_comb begin
      for (int c = 0; c < NC; c++) begin
         if (bank_wr_en)
            bank_rd_data[c*AW +: AW] = bank_acc_mode ? mem[bank_addr][c] + bank_psum[c*AW +: AW]
                                                     : bank_psum[c*AW +: AW];
         else
            bank_rd_data[c*AW +: AW] = mem[bank_addr][c];
      end
   end
   always @(posedge clk) begin
      if (bank_wr_en)
         for (int c = 0; c < NC; c++)
            mem[bank_addr][c] = bank_acc_mode ? mem[bank_addr][c] + bank_psum[c*AW +: AW]
                                              : bank_psum[c*AW +: AW];
   end

   function automatic logic [W-1:0] row_vec(input int r);
      logic [W-1:0] v;
      for (int c = 0; c < NC; c++) v[c*AW +: AW] = mem[r][c];
      return v;
   endfunction

   function automatic logic [W-1:0] preload_vec(input int r);
      logic [W-1:0] v;
      for (int c = 0; c < NC; c++) v[c*AW +: AW] = AW'(r * 16 + c);
      return v;
   endfunction

   task automatic preload();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < NC; c++) mem[r][c] = AW'(r * 16 + c);
   endtask

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard: rows a drain must deliver, in order, filled when a start is accepted.
   typedef struct {
      logic [D-1:0] row;
      logic [W-1:0] data;
      logic         last;
   } beat_t;
   beat_t exp_q[$];

   bit           mdl_busy  = 1'b0;
   bit           done_pend = 1'b0;
   bit           held      = 1'b0;
   logic [W-1:0] held_data;
   logic [D:0]   held_rl;
   int           hs_count, done_cnt, first_hs, last_hs, done_cyc, last_row;

   always @(negedge clk) begin
      beat_t e;
      bit    nd, nb;
      int    n;
      if (rst) begin
         chk("rst_ctrl", {busy, done, m_valid, m_last, bank_wr_en, bank_acc_mode}, '0);
         chk("rst_row_addr", {m_row, bank_addr}, '0);
         chk("rst_data", m_data, '0);
         exp_q.delete();
         mdl_busy  = 1'b0;
         done_pend = 1'b0;
         held      = 1'b0;
      end else begin
         chk("busy", busy, mdl_busy);
         chk("done", done, done_pend);
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
`ifndef CLEAR_ON_READ_EN
         chk("bank_write_side", {bank_wr_en, bank_acc_mode, bank_psum}, '0);
`endif
         if (held) begin
            chk("stall_valid", m_valid, 1'b1);
            chk("stall_data", m_data, held_data);
            chk("stall_row_last", {m_row, m_last}, held_rl);
         end
         nd = 1'b0;
         nb = mdl_busy;
         if (m_valid && m_ready) begin
            chk("beat_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("beat_row", m_row, e.row);
               chk("beat_data", m_data, e.data);
               chk("beat_last", m_last, e.last);
               if (hs_count == 0) first_hs = cyc;
               last_hs  = cyc;
               last_row = int'(m_row);
               hs_count++;
               if (e.last) begin
                  nd = 1'b1;
                  nb = 1'b0;
               end
            end
         end
         if (!mdl_busy && start) begin
            if (num_rows == '0) begin
               nd = 1'b1;
            end else begin
               nb = 1'b1;
               n  = (int'(num_rows) > ROWS) ? ROWS : int'(num_rows);
               for (int r = 0; r < n; r++) begin
                  e.row  = D'(r);
                  e.data = row_vec(r);
                  e.last = (r == n - 1);
                  exp_q.push_back(e);
               end
            end
         end
         held      = m_valid && !m_ready;
         held_data = m_data;
         held_rl   = {m_row, m_last};
         mdl_busy  = nb;
         done_pend = nd;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      hs_count = 0;
      done_cnt = 0;
      first_hs = -1;
      last_hs  = -1;
      done_cyc = -1;
      last_row = -1;
   endtask

   task automatic pulse_start(input int nr, output int t);
      start    = 1'b1;
      num_rows = (D+1)'(nr);
      t        = cyc;
      step();
      start    = 1'b0;
   endtask

   task automatic run_until_done(input int budget, input bit rnd, input string name);
      for (int k = 0; k < budget && done_cnt == 0; k++) begin
         if (rnd) m_ready = 1'($urandom_range(0, 1));
         step();
      end
      m_ready = 1'b1;
      chk(name, done_cnt != 0, 1'b1);
      step();
      step();
   endtask

   initial begin
      int t;
      preload();
      clear_stats();
      step(); step(); step();
      rst = 1'b0;
      step();
      chk("post_reset_idle", {busy, m_valid, done}, '0);

      // 197-row drain, PPU always ready
      clear_stats();
      pulse_start(197, t);
      run_until_done(1000, 1'b0, "t197_timeout");
      chk("t197_count", hs_count, 197);
      chk("t197_first", first_hs, t + 2);
      chk("t197_last", last_hs, t + 2 + 196 * SP);
      chk("t197_done", done_cyc, t + 3 + 196 * SP);
      chk("t197_lastrow", last_row, 196);

      // zero rows: done only
      clear_stats();
      pulse_start(0, t);
      step(); step();
      chk("t0_done", done_cyc, t + 1);
      chk("t0_beats", hs_count, 0);

      // clamp to bank depth
      preload();
      clear_stats();
      pulse_start(300, t);
      run_until_done(2000, 1'b0, "t300_timeout");
      chk("t300_count", hs_count, 256);
      chk("t300_lastrow", last_row, 255);
      chk("t300_span", last_hs - first_hs, 255 * SP);

      // backpressure, with an ignored start mid-drain
      preload();
      clear_stats();
      pulse_start(64, t);
      for (int k = 0; k < 20; k++) begin
         m_ready  = 1'($urandom_range(0, 1));
         start    = (k == 10);
         num_rows = (D+1)'(5);
         step();
      end
      start = 1'b0;
      run_until_done(2000, 1'b1, "tbp_timeout");
      chk("tbp_count", hs_count, 64);
      chk("tbp_done_once", done_cnt, 1);

      // reset in the middle of a drain, then a fresh drain
      preload();
      clear_stats();
      pulse_start(64, t);
      for (int k = 0; k < 200 && hs_count < 10; k++) step();
      chk("trst_reach", hs_count >= 10, 1'b1);
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
      chk("trst_idle", {busy, m_valid, done}, '0);
      preload();
      clear_stats();
      pulse_start(4, t);
      run_until_done(200, 1'b0, "trst_timeout");
      chk("trst_count", hs_count, 4);
      chk("trst_first", first_hs, t + 2);

`ifdef CLEAR_ON_READ_EN
      // clear-after-read: 8 rows drained then zeroed, row 8 untouched
      preload();
      clear_stats();
      pulse_start(8, t);
      run_until_done(200, 1'b0, "tclr_timeout");
      chk("tclr_count", hs_count, 8);
      chk("tclr_span", last_hs - first_hs, 14);
      for (int r = 0; r < 8; r++) chk("tclr_zeroed", row_vec(r), '0);
      chk("tclr_row8", row_vec(8), preload_vec(8));
`endif

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
`default_nettype wire
